// File: rtl/cvxif_instr_pkg.sv
// Shared CV-X-IF instruction table for the custom0..3 opcode set.
// Entry index is the execution slot; the first matching entry wins.
package cvxif_instr_pkg;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] pattern;
    logic        writeback;
  } instr_entry_t;

  localparam int NUM_INSTR = 4;

  localparam instr_entry_t INSTR_TABLE [NUM_INSTR] = '{
    '{mask: 32'h0000_007F, pattern: 32'h0000_000B, writeback: 1'b1},  // custom0
    '{mask: 32'h0000_007F, pattern: 32'h0000_002B, writeback: 1'b1},  // custom1
    '{mask: 32'h0000_007F, pattern: 32'h0000_005B, writeback: 1'b1},  // custom2
    '{mask: 32'h0000_007F, pattern: 32'h0000_007B, writeback: 1'b1}   // custom3
  };

endpackage

// File: rtl/cvxif_seq_pkg.sv
// Types and constants shared by the coprocessor sequencer and its decoder.
package cvxif_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } fsm_state_e;

  // Control half of a buffer entry; id and operands live in separate
  // parameter-width arrays next to it.
  typedef struct packed {
    logic       valid;
    logic       committed;
    logic       dead;
    logic       writeback;
    logic [4:0] rd;
    logic [1:0] slot;
  } entry_t;

  localparam int NUM_SLOTS = 4;

  // Execution latency in cycles, indexed by decoded slot.
  localparam logic [2:0] LAT [NUM_SLOTS] = '{3'd1, 3'd2, 3'd3, 3'd4};

endpackage

// File: rtl/cvxif_seq_decoder.sv
// Combinational match of an instruction word against the shared table.
// Returns hit, slot index and writeback flag; lowest index wins.
module cvxif_seq_decoder
  import cvxif_instr_pkg::*;
(
  input  logic [31:0] instr,
  output logic        hit,
  output logic [1:0]  slot,
  output logic        writeback
);

  // NOTE: every output gets a default before the loop, so no latch is
  // inferred when nothing in the table matches.
  always_comb begin
    hit       = 1'b0;
    slot      = 2'd0;
    writeback = 1'b0;
    // Walk from the top so the lowest matching index is written last.
    for (int i = NUM_INSTR - 1; i >= 0; i--) begin
      if ((instr & INSTR_TABLE[i].mask) == INSTR_TABLE[i].pattern) begin
        hit       = 1'b1;
        slot      = 2'(i);
        writeback = INSTR_TABLE[i].writeback;
      end
    end
  end

endmodule

// File: rtl/cvxif_copro_sequencer.sv
// CV-X-IF coprocessor sequencer: decode/accept, in-order buffer, commit/kill,
// fixed-latency execute, result handshake. Macro CVXIF_SEQ_PERF_CNT_EN adds perf counters.
module cvxif_copro_sequencer
  import cvxif_seq_pkg::*;
#(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [31:0]           issue_instr_i,
  input  logic [X_ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]       issue_rs1_i,
  input  logic [XLEN-1:0]       issue_rs2_i,
  output logic                  issue_accept_o,
  output logic                  issue_writeback_o,
  input  logic                  commit_valid_i,
  input  logic [X_ID_WIDTH-1:0] commit_id_i,
  input  logic                  commit_kill_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [X_ID_WIDTH-1:0] result_id_o,
  output logic [4:0]            result_rd_o,
  output logic [XLEN-1:0]       result_data_o,
  output logic                  result_we_o,
  output logic                  busy_o,
  output logic [31:0]           perf_accepted_o,
  output logic [31:0]           perf_killed_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic       dec_hit;
  logic [1:0] dec_slot;
  logic       dec_wb;

  cvxif_seq_decoder u_decoder (
    .instr     (issue_instr_i),
    .hit       (dec_hit),
    .slot      (dec_slot),
    .writeback (dec_wb)
  );

  entry_t                ctrl_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_q   [DEPTH];
  logic [XLEN-1:0]       rs1_q  [DEPTH];
  logic [XLEN-1:0]       rs2_q  [DEPTH];

  logic [PW:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [PW-1:0] wr_idx, rd_idx;
  logic          empty, full_d, ready_q;
  entry_t        head;

  fsm_state_e      state_q, state_d;
  logic [2:0]      cnt_q;
  logic [1:0]      op_slot_q;
  logic [XLEN-1:0] op_a_q, op_b_q, alu_res;

  logic [X_ID_WIDTH-1:0] res_id_q;
  logic [4:0]            res_rd_q;
  logic [XLEN-1:0]       res_data_q;
  logic                  res_we_q;

  logic             push, pop, launch, dead_pop, res_pop, new_hit;
  logic [DEPTH-1:0] cm_hit;

  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];
  assign head   = ctrl_q[rd_idx];
  assign empty  = (wr_ptr_q == rd_ptr_q);

  // Ready comes straight from a flop so it never depends on same-cycle inputs.
  assign issue_ready_o     = ready_q;
  assign issue_accept_o    = ready_q && dec_hit;
  assign issue_writeback_o = ready_q && dec_hit && dec_wb;
  assign push              = issue_valid_i && ready_q && dec_hit;
  assign pop               = dead_pop || res_pop;
  assign busy_o            = !empty || (state_q != IDLE);

  assign wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, push};
  assign rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, pop};
  assign full_d   = (wr_ptr_d[PW] != rd_ptr_d[PW]) &&
                    (wr_ptr_d[PW-1:0] == rd_ptr_d[PW-1:0]);

  // A commit/kill for the id being pushed this cycle lands on the new entry.
  assign new_hit = commit_valid_i && (commit_id_i == issue_id_i);

  // The executing head is already committed, so commit/kill no longer touch it.
  always_comb begin
    cm_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cm_hit[i] = commit_valid_i && ctrl_q[i].valid && (id_q[i] == commit_id_i) &&
                  !((state_q != IDLE) && (PW'(i) == rd_idx));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ready_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ctrl_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ready_q  <= !full_d;
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx == PW'(i))) begin
          ctrl_q[i] <= '{valid:     1'b1,
                         committed: new_hit && !commit_kill_i,
                         dead:      new_hit && commit_kill_i,
                         writeback: dec_wb,
                         rd:        issue_instr_i[11:7],
                         slot:      dec_slot};
        end else if (pop && (rd_idx == PW'(i))) begin
          ctrl_q[i] <= '0;
        end else if (cm_hit[i]) begin
          if (commit_kill_i) ctrl_q[i].dead      <= 1'b1;
          else               ctrl_q[i].committed <= 1'b1;
        end
      end
    end
  end

  // NOTE: payload storage has no reset; an entry is only read while its
  // valid bit (which is reset) is set.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[wr_idx]  <= issue_id_i;
      rs1_q[wr_idx] <= issue_rs1_i;
      rs2_q[wr_idx] <= issue_rs2_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!empty && !head.dead && head.committed) state_d = EXEC;
      EXEC:    if (cnt_q == 3'd0) state_d = RESULT;
      RESULT:  if (result_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    launch         = 1'b0;
    dead_pop       = 1'b0;
    res_pop        = 1'b0;
    result_valid_o = 1'b0;
    result_id_o    = '0;
    result_rd_o    = '0;
    result_data_o  = '0;
    result_we_o    = 1'b0;
    unique case (state_q)
      IDLE: begin
        dead_pop = !empty && head.dead;
        launch   = !empty && !head.dead && head.committed;
      end
      RESULT: begin
        result_valid_o = 1'b1;
        result_id_o    = res_id_q;
        result_rd_o    = res_rd_q;
        result_data_o  = res_data_q;
        result_we_o    = res_we_q;
        res_pop        = result_ready_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (op_slot_q)
      2'd0:    alu_res = op_a_q + op_b_q;
      2'd1:    alu_res = op_a_q - op_b_q;
      2'd2:    alu_res = op_a_q ^ op_b_q;
      default: alu_res = op_a_q & op_b_q;
    endcase
  end

  // The head stays in the buffer until the result handshake, so the result
  // tag is read from it at the end of EXEC.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      op_slot_q  <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_id_q   <= '0;
      res_rd_q   <= '0;
      res_data_q <= '0;
      res_we_q   <= 1'b0;
    end else begin
      if (launch) begin
        op_a_q    <= rs1_q[rd_idx];
        op_b_q    <= rs2_q[rd_idx];
        op_slot_q <= head.slot;
        cnt_q     <= LAT[head.slot] - 3'd1;
      end else if ((state_q == EXEC) && (cnt_q != 3'd0)) begin
        cnt_q <= cnt_q - 3'd1;
      end
      if ((state_q == EXEC) && (cnt_q == 3'd0)) begin
        res_data_q <= alu_res;
        res_id_q   <= id_q[rd_idx];
        res_rd_q   <= head.rd;
        res_we_q   <= head.writeback;
      end
    end
  end

`ifdef CVXIF_SEQ_PERF_CNT_EN
  logic [31:0] perf_acc_q, perf_kill_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_acc_q  <= '0;
      perf_kill_q <= '0;
    end else begin
      if (push && (perf_acc_q != '1))      perf_acc_q  <= perf_acc_q + 32'd1;
      if (dead_pop && (perf_kill_q != '1)) perf_kill_q <= perf_kill_q + 32'd1;
    end
  end

  assign perf_accepted_o = perf_acc_q;
  assign perf_killed_o   = perf_kill_q;
`else
  assign perf_accepted_o = '0;
  assign perf_killed_o   = '0;
`endif

endmodule

// File: doc/cvxif_copro_sequencer.md
Name: cvxif_copro_sequencer

Overview:
- Coprocessor-side CV-X-IF controller for the custom0..3 opcode set.
- Decodes issued instructions against the shared instruction table and accepts or rejects each one in the same cycle.
- Buffers accepted instructions in order, holds each until the core commits or kills it, executes it with a fixed per-opcode latency, and returns results through a valid/ready result handshake.
- Sits between the CVA6 CV-X-IF port and the coprocessor datapath.

Parameters:
- XLEN, 64: operand and result width.
- X_ID_WIDTH, 4: instruction id width.
- DEPTH, 4: in-flight buffer entries; power of two, 2..16.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  issue request valid
- issue_ready_o  out  1  issue accepted this cycle
- issue_instr_i  in  32  instruction word
- issue_id_i  in  X_ID_WIDTH  instruction id
- issue_rs1_i  in  XLEN  operand 1
- issue_rs2_i  in  XLEN  operand 2
- issue_accept_o  out  1  decode hit (valid only while issue_ready_o is high)
- issue_writeback_o  out  1  decoded writeback flag
- commit_valid_i  in  1  commit strobe
- commit_id_i  in  X_ID_WIDTH  committed id
- commit_kill_i  in  1  kill instead of commit
- result_valid_o  out  1  result valid
- result_ready_i  in  1  core accepts result
- result_id_o  out  X_ID_WIDTH  result id
- result_rd_o  out  5  destination register, instr[11:7]
- result_data_o  out  XLEN  result value
- result_we_o  out  1  writeback enable
- busy_o  out  1  buffer non-empty or FSM not in IDLE
- perf_accepted_o  out  32  accepted-instruction count
- perf_killed_o  out  32  killed-instruction count

Behaviour:
- Reset: every output is 0. Buffer is empty, FSM is in IDLE, counters are 0. Reset asserted mid-operation discards all entries immediately.
- Decode: combinational match `(instr & mask) == pattern` over the table. First hit wins. A hit yields slot index 0..3; a miss gives accept=0 and writeback=0.
- Issue: `issue_ready_o = !full`.
  - On `valid && ready && hit`, push {id, rd, slot, rs1, rs2, writeback, committed=0}.
  - On a miss, the core still sees ready=1 and accept=0; nothing is pushed.
  - When the buffer is full, ready=0 and accept/writeback are 0.
- Commit: `commit_valid_i` compares `commit_id_i` against all valid entries.
  - Match with kill=0: set the committed bit.
  - Match with kill=1: mark the entry dead.
  - No match: ignored.
  - Commit arriving in the same cycle as the push of the same id: it applies to the new entry.
- FSM states IDLE, EXEC, RESULT:
  - IDLE: if the head entry is dead, pop it with no result (1 cycle per dead entry). If the head is committed, latch the operands, load `cnt = LAT[slot]-1`, and go to EXEC. Otherwise stay in IDLE.
  - EXEC: decrement cnt; at 0, register the result and go to RESULT.
  - RESULT: hold `result_valid_o=1` with stable outputs until result_ready_i. On the handshake, pop and go to IDLE.
  - Latency from entering EXEC to result_valid is LAT[slot] cycles.
  - A kill targeting the executing entry is ignored: the entry is already committed.
- Ops, XLEN-wide, wrap-around arithmetic:
  - slot0: rs1+rs2
  - slot1: rs1-rs2
  - slot2: rs1^rs2
  - slot3: rs1 & rs2
- result_we_o = entry writeback flag.
- Push and pop in the same cycle while full: not allowed. Ready depends only on the registered full flag.
- Pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit.

Optional Feature:
- CVXIF_SEQ_PERF_CNT_EN defined:
  - perf_accepted_o counts accepted issues.
  - perf_killed_o counts dead pops.
  - Both counters are 32-bit, saturating at all-ones.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package cvxif_seq_pkg holds:
  - entry struct typedef;
  - fsm_state_e enum;
  - LAT constant array {1,2,3,4}, indexed by slot.
- The table itself stays in the existing instruction package.
- One sub-module, cvxif_seq_decoder: combinational table match returning hit, slot and writeback.

Test Plan:
- Issue instr 0x0000000B (custom0), id=3, rs1=5, rs2=7; commit id=3 -> accept=1; result_valid 1 cycle after EXEC with data=12, rd=0, id=3.
- Issue 0x00000033 (OP opcode) -> ready=1, accept=0; buffer stays empty; busy_o=0.
- Issue custom1 (rs1=0, rs2=1) then custom3; commit both; hold result_ready_i=0 for 5 cycles -> result 1 held stable with data=all-ones (wrap); results come out in order with custom3 latency 4.
- Fill DEPTH=4 uncommitted -> issue_ready_o=0 on the 5th; commit id0 -> ready returns only after id0 pops.
- Issue ids 1,2; kill id1, commit id2 -> id1 produces no result; id2 result follows; perf_killed_o=1 with macro, 0 without.
- Assert rst_ni low during RESULT -> result_valid_o=0 at once; buffer empty after release.
